tone_period_meter: RTL

- Receive-side counterpart of the tone generator: measures the period and high time of an incoming square wave, in 10 ns clock units.
- Input may come from a loopback of audPWM, a PMOD pin, or a comparator output.
- Output uses the same units as the generator's period input, so a measured value can be fed straight back to the generator or compared against the note-period table.
- Sits beside the sound path in the top level and feeds note-recognition logic and the 7-segment display.

---
 rtl/tone_pkg.sv | 21 ++
 rtl/sync_edge_detect.sv | 35 +++
 rtl/tone_period_meter.sv | 109 ++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone generator / period meter pair.
// Note periods are in 10 ns clock cycles, matching the generator's period input.
package tone_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam int unsigned NOTE_C4 = 382219;
  localparam int unsigned NOTE_D4 = 340530;
  localparam int unsigned NOTE_E4 = 303370;
  localparam int unsigned NOTE_F4 = 286344;
  localparam int unsigned NOTE_G4 = 255102;
  localparam int unsigned NOTE_A4 = 227273;
  localparam int unsigned NOTE_B4 = 202478;
  localparam int unsigned NOTE_C5 = 191113;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input, plus a delay flop that
// yields a one-cycle rising-edge strobe and the synchronized level.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic lvl
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign lvl  = s2_q;

endmodule

// File: rtl/tone_period_meter.sv
// Measures rising-to-rising period and high time of an incoming square wave in
// clk cycles; rejects edges closer than MIN_PERIOD and times out at MAX_PERIOD.
module tone_period_meter
  import tone_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEFAULT,
  parameter int unsigned MIN_PERIOD = 1000,
  parameter int unsigned MAX_PERIOD = 4000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             period_valid,
  output logic             no_signal
);

  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] MAX_P = WIDTH'(MAX_PERIOD);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic rise, lvl;

  sync_edge_detect u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .rise     (rise),
    .lvl      (lvl)
  );

  meter_state_e     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             accept;

  // The first edge out of IDLE is always taken; later edges must clear MIN_PERIOD.
  assign accept = rise && ((state_q == IDLE) || (cnt_q >= MIN_P));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;

    if (accept) begin
      cnt_d  = ONE;
      hcnt_d = {{(WIDTH-1){1'b0}}, lvl};
    end else begin
      cnt_d = (cnt_q >= MAX_P) ? MAX_P : cnt_q + ONE;
      if (lvl && (hcnt_q < MAX_P)) begin
        hcnt_d = hcnt_q + ONE;
      end
    end

    // Edge acceptance takes priority over timeout when both occur together.
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (accept) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
        end else if (cnt_q >= MAX_P) begin
          state_d  = IDLE;
          period_d = '0;
          high_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign no_signal    = (state_q == IDLE);

endmodule
